vga_pattern_gen: RTL and testbench

//  Parametrised VGA timing plus test-pattern generator: next generation of the fixed 640x480 chessboard driver.

---
 rtl/vga_pattern_gen.sv | 183 ++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   VGA timing plus test-pattern generator. Raster timing comes entirely from
//   parameters and the sync polarity is selectable. Four runtime pattern modes
//   are available: checkerboard, eight colour bars, grey ramp and solid
//   foreground. Mode, square size and colours are shadowed once per frame, so
//   input changes never tear a frame.
//
// Ports
//   i_clk          pixel clock
//   i_rst_n        asynchronous active-low reset
//   i_mode         0 checkerboard, 1 colour bars, 2 grey ramp, 3 solid fg
//   i_sq_log2      checker square edge = 2^(i_sq_log2+3) pixels
//   i_fg_color     RGB332 foreground colour
//   i_bg_color     RGB332 background colour
//   o_vga_rgb      RGB332 pixel, 0 outside active video
//   o_vga_hs       horizontal sync, active level HS_POL
//   o_vga_vs       vertical sync, active level VS_POL
//   o_vga_de       active-video enable
//   o_pix_x        active x coordinate, 0 when o_vga_de=0
//   o_pix_y        active y coordinate, 0 when o_vga_de=0
//   o_frame_start  one-cycle pulse on the first cycle of vsync
//
// All outputs are registered from the same counter values, so they carry one
// cycle of latency and stay mutually aligned.

module vga_pattern_gen #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [1:0]       i_mode,
  input  logic [2:0]       i_sq_log2,
  input  logic [7:0]       i_fg_color,
  input  logic [7:0]       i_bg_color,
  output logic [7:0]       o_vga_rgb,
  output logic             o_vga_hs,
  output logic             o_vga_vs,
  output logic             o_vga_de,
  output logic [CNT_W-1:0] o_pix_x,
  output logic [CNT_W-1:0] o_pix_y,
  output logic             o_frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C     = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C     = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C    = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_START_C    = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_ACT_LAST_C = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST_C = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BAR_LAST_C   = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0] r_cnt_h;
  logic [CNT_W-1:0] r_cnt_v;
  logic [1:0]       r_mode;
  logic [2:0]       r_sq_log2;
  logic [7:0]       r_fg;
  logic [7:0]       r_bg;
  logic [CNT_W-1:0] r_bar_pos;
  logic [2:0]       r_bar_idx;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_de;
  logic [CNT_W-1:0] w_x;
  logic [CNT_W-1:0] w_y;
  logic [3:0]       w_sh;
  logic [CNT_W-1:0] w_x_sh;
  logic [CNT_W-1:0] w_y_sh;
  logic [2:0]       w_bar_b;
  logic [7:0]       w_pix;

  assign w_h_last = (r_cnt_h == H_LAST_C);
  assign w_v_last = (r_cnt_v == V_LAST_C);
  assign w_h_act  = (r_cnt_h >= H_START_C) && (r_cnt_h <= H_ACT_LAST_C);
  assign w_v_act  = (r_cnt_v >= V_START_C) && (r_cnt_v <= V_ACT_LAST_C);
  assign w_de     = w_h_act && w_v_act;
  assign w_x      = r_cnt_h - H_START_C;
  assign w_y      = r_cnt_v - V_START_C;

  // Raster counters; line and frame wrap can land on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (w_h_last) begin
      r_cnt_h <= '0;
      r_cnt_v <= w_v_last ? '0 : r_cnt_v + C_ONE;
    end else begin
      r_cnt_h <= r_cnt_h + C_ONE;
    end
  end

  // Shadow registers load on the very last cycle of a frame, so new settings
  // apply from the frame_start cycle onward and never mid-frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= 2'd0;
      r_sq_log2 <= 3'd2;
      r_fg      <= 8'hFF;
      r_bg      <= 8'h00;
    end else if (w_h_last && w_v_last) begin
      r_mode    <= i_mode;
      r_sq_log2 <= i_sq_log2;
      r_fg      <= i_fg_color;
      r_bg      <= i_bg_color;
    end
  end

  // Bar tracker aligned with the current cnt_h: it is cleared on every
  // non-active pixel, so it reads bar 0 at x=0. Bar 7 absorbs any remainder
  // pixels when H_ACTIVE is not a multiple of 8.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bar_pos <= '0;
      r_bar_idx <= 3'd0;
    end else if (!w_h_act) begin
      r_bar_pos <= '0;
      r_bar_idx <= 3'd0;
    end else if (r_bar_idx != 3'd7) begin
      if (r_bar_pos == BAR_LAST_C) begin
        r_bar_pos <= '0;
        r_bar_idx <= r_bar_idx + 3'd1;
      end else begin
        r_bar_pos <= r_bar_pos + C_ONE;
      end
    end
  end

  assign w_sh    = {1'b0, r_sq_log2} + 4'd3;
  assign w_x_sh  = w_x >> w_sh;
  assign w_y_sh  = w_y >> w_sh;
  assign w_bar_b = ~r_bar_idx;

  always_comb begin
    w_pix = 8'h00;
    case (r_mode)
      2'd0:    w_pix = (w_x_sh[0] ^ w_y_sh[0]) ? r_fg : r_bg;
      2'd1:    w_pix = {{3{w_bar_b[2]}}, {3{w_bar_b[1]}}, {2{w_bar_b[0]}}};
      2'd2:    w_pix = {w_x[7:5], w_x[7:5], w_x[7:6]};
      default: w_pix = r_fg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vga_hs      <= ~HS_POL;
      o_vga_vs      <= ~VS_POL;
      o_vga_de      <= 1'b0;
      o_vga_rgb     <= 8'h00;
      o_pix_x       <= '0;
      o_pix_y       <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_vga_hs      <= (r_cnt_h < H_SYNC_C) ? HS_POL : ~HS_POL;
      o_vga_vs      <= (r_cnt_v < V_SYNC_C) ? VS_POL : ~VS_POL;
      o_vga_de      <= w_de;
      o_vga_rgb     <= w_de ? w_pix : 8'h00;
      o_pix_x       <= w_de ? w_x : '0;
      o_pix_y       <= w_de ? w_y : '0;
      o_frame_start <= (r_cnt_h == '0) && (r_cnt_v == '0);
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Testbench for vga_pattern_gen using a reduced raster (84 x 47 total,
// 68 x 40 active) so that several whole frames fit in a short run. A second
// instance with both sync polarities inverted runs alongside the first.
// Expected pixels are pushed into a scoreboard queue ahead of the frame in
// which they appear; a monitor pops and compares them as the DUT presents
// the matching active pixel.

module tb_vga_pattern_gen;

  localparam int HS = 8, HB = 4, HA = 68, HF = 4;
  localparam int VS = 2, VB = 3, VA = 40, VF = 2;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [2:0]    sq_log2;
  logic [7:0]    fg, bg;

  logic [7:0]    rgb, p_rgb;
  logic          hs, vs, de, fs;
  logic          p_hs, p_vs, p_de, p_fs;
  logic [CW-1:0] px, py, p_px, p_py;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_sq_log2(sq_log2),
    .i_fg_color(fg), .i_bg_color(bg),
    .o_vga_rgb(rgb), .o_vga_hs(hs), .o_vga_vs(vs), .o_vga_de(de),
    .o_pix_x(px), .o_pix_y(py), .o_frame_start(fs)
  );

  vga_pattern_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(CW)
  ) u_pol (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_sq_log2(sq_log2),
    .i_fg_color(fg), .i_bg_color(bg),
    .o_vga_rgb(p_rgb), .o_vga_hs(p_hs), .o_vga_vs(p_vs), .o_vga_de(p_de),
    .o_pix_x(p_px), .o_pix_y(p_py), .o_frame_start(p_fs)
  );

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [7:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  int   checks     = 0;
  int   failures   = 0;
  int   frame_no   = 0;
  int   blank_viol = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int f, input int x, input int y, input logic [7:0] c);
    exp_t e;
    e.frame = f; e.x = x; e.y = y; e.rgb = c;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      frame_no = 0;
    end else begin
      if (fs) frame_no++;
      if (!de && (rgb != 8'h00 || px != '0 || py != '0)) blank_viol++;
      while (sb_q.size() > 0 && sb_q[0].frame < frame_no) begin
        checks++;
        failures++;
        $display("FAIL sb_missed frame=%0d x=%0d y=%0d actual=not_seen required=0x%0h",
                 sb_q[0].frame, sb_q[0].x, sb_q[0].y, sb_q[0].rgb);
        void'(sb_q.pop_front());
      end
      if (sb_q.size() > 0 && de && sb_q[0].frame == frame_no &&
          int'(px) == sb_q[0].x && int'(py) == sb_q[0].y) begin
        chk($sformatf("pix_f%0d_x%0d_y%0d", sb_q[0].frame, sb_q[0].x, sb_q[0].y),
            int'(rgb), int'(sb_q[0].rgb));
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_hs"},  int'(hs),   1);
    chk({tag, "_vs"},  int'(vs),   1);
    chk({tag, "_de"},  int'(de),   0);
    chk({tag, "_rgb"}, int'(rgb),  0);
    chk({tag, "_px"},  int'(px),   0);
    chk({tag, "_py"},  int'(py),   0);
    chk({tag, "_fs"},  int'(fs),   0);
    chk({tag, "_pol_hs"}, int'(p_hs), 0);
    chk({tag, "_pol_vs"}, int'(p_vs), 0);
  endtask

  task automatic wait_fs();
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (fs) return;
    end
    chk("wait_fs_timeout", 0, 1);
  endtask

  task automatic wait_y(input int y);
    for (int i = 0; i < 2 * FT; i++) begin
      @(negedge clk);
      if (de && int'(py) == y) return;
    end
    chk("wait_y_timeout", 0, 1);
  endtask

  // Called on the negedge where frame_start is visible; returns on the
  // negedge one frame later.
  task automatic measure_frame(input string tag);
    int hs_n = 0, vs_n = 0, de_n = 0, lines = 0, de_lines = 0;
    int ph_n = 0, pv_n = 0, first_de = -1, line2 = -1, px0 = -1, py0 = -1;
    logic prev_hs = 1'b0, prev_de = 1'b0;
    for (int i = 0; i < FT; i++) begin
      if (hs == 1'b0) begin
        hs_n++;
        if (!prev_hs) begin
          lines++;
          if (lines == 2) line2 = i;
        end
      end
      prev_hs = (hs == 1'b0);
      if (vs == 1'b0) vs_n++;
      if (p_hs == 1'b1) ph_n++;
      if (p_vs == 1'b1) pv_n++;
      if (de) begin
        de_n++;
        if (!prev_de) de_lines++;
        if (first_de < 0) begin
          first_de = i; px0 = int'(px); py0 = int'(py);
        end
      end
      prev_de = de;
      @(negedge clk);
    end
    chk({tag, "_frame_period"}, int'(fs), 1);
    chk({tag, "_hs_active_clks"}, hs_n, HS * VT);
    chk({tag, "_hs_lines"}, lines, VT);
    chk({tag, "_hs_period"}, line2, HT);
    chk({tag, "_vs_active_clks"}, vs_n, VS * HT);
    chk({tag, "_de_clks"}, de_n, HA * VA);
    chk({tag, "_de_lines"}, de_lines, VA);
    chk({tag, "_first_de_offset"}, first_de, (VS + VB) * HT + HS + HB);
    chk({tag, "_first_de_xy"}, px0 * 1000 + py0, 0);
    chk({tag, "_pol_hs_high_clks"}, ph_n, HS * VT);
    chk({tag, "_pol_vs_high_clks"}, pv_n, VS * HT);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd0; sq_log2 = 3'd2; fg = 8'hFF; bg = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("rst");

    // Frame 1: reset shadows (checker, 32 px squares, FF/00). A switch to
    // solid 5A at y=20 must not affect the rest of this frame.
    push(1, 0, 0, 8'h00);  push(1, 31, 0, 8'h00); push(1, 32, 0, 8'hFF);
    push(1, 40, 10, 8'hFF);
    push(1, 0, 32, 8'hFF); push(1, 32, 32, 8'h00);
    push(1, 0, 39, 8'hFF); push(1, 67, 39, 8'hFF);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_fs", int'(fs), 1);
    fork
      measure_frame("f1");
      begin
        wait_y(20);
        mode = 2'd3; fg = 8'h5A;
        push(2, 0, 0, 8'h5A); push(2, 67, 20, 8'h5A); push(2, 67, 39, 8'h5A);
      end
    join

    // Now at start of frame 2; set up frame 3: colour bars.
    mode = 2'd1;
    push(3, 0, 0, 8'hFF);  push(3, 7, 0, 8'hFF);  push(3, 8, 0, 8'hFC);
    push(3, 16, 0, 8'hE3); push(3, 32, 0, 8'h1F); push(3, 40, 0, 8'h1C);
    push(3, 48, 0, 8'h03); push(3, 56, 0, 8'h00); push(3, 67, 0, 8'h00);
    push(3, 0, 25, 8'hFF); push(3, 16, 25, 8'hE3); push(3, 67, 25, 8'h00);
    wait_fs();

    // Frame 4: grey ramp.
    mode = 2'd2;
    push(4, 0, 3, 8'h00);  push(4, 31, 3, 8'h00); push(4, 32, 3, 8'h24);
    push(4, 64, 3, 8'h49); push(4, 67, 3, 8'h49);
    wait_fs();

    // Frame 5: checker with 8 px squares and custom colours.
    mode = 2'd0; sq_log2 = 3'd0; fg = 8'hE0; bg = 8'h1C;
    push(5, 0, 0, 8'h1C);  push(5, 8, 0, 8'hE0);
    push(5, 0, 8, 8'hE0);  push(5, 8, 8, 8'h1C);  push(5, 16, 8, 8'hE0);
    push(5, 15, 15, 8'h1C);
    wait_fs();

    // Reset in the middle of frame 5.
    wait_y(25);
    chk("sb_drained_before_reset", sb_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    repeat (3) @(negedge clk);
    push(1, 0, 0, 8'h00); push(1, 32, 0, 8'hFF); push(1, 32, 32, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_first_fs", int'(fs), 1);
    measure_frame("post_rst");

    chk("blanking_violations", blank_viol, 0);
    chk("sb_left_at_end", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
